rpn_eval: RTL and testbench

//  Downstream stage of the infix->RPN converter. Consumes the converter's RPN

---
 rtl/rpn_pkg.sv | 42 ++++
 rtl/rpn_eval_if.sv | 22 ++
 rtl/rpn_eval_stack.sv | 54 +++++
 rtl/rpn_eval.sv | 149 ++++++++++++++
 tb/tb_rpn_eval.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN converter/evaluator pair: ASCII tokens,
// error codes, evaluator FSM states and operand-stack operations.
package rpn_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3D;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_OVF   = 3'd2;
  localparam logic [2:0] ERR_DIV0  = 3'd3;
  localparam logic [2:0] ERR_CHAR  = 3'd4;
  localparam logic [2:0] ERR_LEFT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESULT
  } state_t;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_REPLACE2,
    STK_CLEAR
  } stk_op_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_MUL) || (c == CH_DIV);
  endfunction

endpackage

// File: rtl/rpn_eval_if.sv
// Character input handshake and result output handshake of the RPN evaluator.
interface rpn_eval_if #(
  parameter int W = 16
);
  logic                IN_STB;
  logic [7:0]          IN_CHAR;
  logic                IN_ACK;
  logic                RES_STB;
  logic signed [W-1:0] RES_VAL;
  logic [2:0]          RES_ERR;
  logic                RES_ACK;

  modport master (
    output IN_STB, IN_CHAR, RES_ACK,
    input  IN_ACK, RES_STB, RES_VAL, RES_ERR
  );

  modport slave (
    input  IN_STB, IN_CHAR, RES_ACK,
    output IN_ACK, RES_STB, RES_VAL, RES_ERR
  );
endinterface

// File: rtl/rpn_eval_stack.sv
// Operand stack: entry 0 is always the top, so top/second need no index math.
module eval_stack
  import rpn_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  stk_op_t                           op,
  input  logic signed [W-1:0]               din,
  output logic signed [W-1:0]               top,
  output logic signed [W-1:0]               second,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              empty
);
  localparam int CW = $clog2(DEPTH+1);

  logic signed [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else begin
      case (op)
        STK_PUSH:     count <= count + CW'(1);
        STK_REPLACE2: count <= count - CW'(1);
        STK_CLEAR:    count <= '0;
        default:      ;
      endcase
    end
  end

  // Entries beyond count are don't-care, so the data array carries no reset.
  always_ff @(posedge CLK) begin
    case (op)
      STK_PUSH: begin
        mem[0] <= din;
        for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
      STK_REPLACE2: begin
        mem[0] <= din;
        for (int i = 1; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      default: ;
    endcase
  end

  assign top    = mem[0];
  assign second = mem[1];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
endmodule

// File: rtl/rpn_eval.sv
// RPN evaluator: accepts one ASCII char per two clocks, executes it on the
// operand stack and returns a signed result plus error code on each '='.
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input logic       CLK,
  input logic       RST,
  rpn_eval_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);

  state_t              state;
  logic [7:0]          char_q;
  logic                in_ack;
  logic                res_stb;
  logic signed [W-1:0] res_val;
  logic [2:0]          res_err;
  logic [2:0]          err_q;
  logic [2:0]          exec_err;

  stk_op_t             stk_op;
  logic signed [W-1:0] stk_din;
  logic signed [W-1:0] stk_top;
  logic signed [W-1:0] stk_second;
  logic [CW-1:0]       stk_count;
  logic                stk_full;
  logic                stk_empty;

  // Dividing the most negative value by -1 wraps back to itself via negation.
  function automatic logic signed [W-1:0] alu_div(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    if (b == '0)      return '0;
    else if (b == '1) return -a;
    else              return a / b;
  endfunction

  function automatic logic signed [W-1:0] alu(input logic [7:0]          op,
                                              input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
    case (op)
      CH_PLUS:  return a + b;
      CH_MINUS: return a - b;
      CH_MUL:   return a * b;
      CH_DIV:   return alu_div(a, b);
      default:  return '0;
    endcase
  endfunction

  eval_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .CLK    (CLK),
    .RST    (RST),
    .op     (stk_op),
    .din    (stk_din),
    .top    (stk_top),
    .second (stk_second),
    .count  (stk_count),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_comb begin
    stk_op   = STK_NOP;
    stk_din  = '0;
    exec_err = ERR_OK;
    case (state)
      ST_EXEC: begin
        if (err_q == ERR_OK && char_q != CH_EQ) begin
          if (is_digit(char_q)) begin
            if (stk_full) exec_err = ERR_OVF;
            else begin
              stk_op  = STK_PUSH;
              stk_din = {{(W-4){1'b0}}, char_q[3:0]};
            end
          end else if (is_op(char_q)) begin
            if (stk_count < CW'(2))                   exec_err = ERR_UNDER;
            else if (char_q == CH_DIV && stk_top == '0) exec_err = ERR_DIV0;
            else begin
              stk_op  = STK_REPLACE2;
              stk_din = alu(char_q, stk_second, stk_top);
            end
          end else if (char_q != CH_SP) begin
            exec_err = ERR_CHAR;
          end
        end
      end
      ST_RESULT: if (res_stb && bus.RES_ACK) stk_op = STK_CLEAR;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && bus.IN_STB && !in_ack) char_q <= bus.IN_CHAR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      in_ack  <= 1'b0;
      res_stb <= 1'b0;
      res_val <= '0;
      res_err <= ERR_OK;
      err_q   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.IN_STB && !in_ack) begin
            in_ack <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          in_ack <= 1'b0;
          if (char_q == CH_EQ) begin
            state   <= ST_RESULT;
            res_val <= '0;
            if (err_q != ERR_OK)           res_err <= err_q;
            else if (stk_empty)            res_err <= ERR_UNDER;
            else if (stk_count > CW'(1))   res_err <= ERR_LEFT;
            else begin
              res_err <= ERR_OK;
              res_val <= stk_top;
            end
          end else begin
            if (err_q == ERR_OK) err_q <= exec_err;
            state <= ST_IDLE;
          end
        end
        ST_RESULT: begin
          if (!res_stb) begin
            res_stb <= 1'b1;
          end else if (bus.RES_ACK) begin
            res_stb <= 1'b0;
            err_q   <= ERR_OK;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.IN_ACK  = in_ack;
  assign bus.RES_STB = res_stb;
  assign bus.RES_VAL = res_val;
  assign bus.RES_ERR = res_err;
endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval: expressions with hand-computed results,
// error codes, result backpressure and mid-expression reset.
module tb_rpn_eval;
  import rpn_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  rpn_eval_if #(.W(16)) bus ();

  rpn_eval #(.W(16), .DEPTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cyc  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    bit got = 1'b0;
    bus.IN_STB  = 1'b1;
    bus.IN_CHAR = c;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.IN_ACK) got = 1'b1;
    end
    ack_cyc    = cyc;
    bus.IN_STB = 1'b0;
    check("ack_seen", got, 1);
    tick();
    check("ack_one_cycle", bus.IN_ACK, 0);
  endtask

  task automatic get_result(output logic [15:0] v, output logic [2:0] e, output int lat);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.RES_STB) got = 1'b1;
      else tick();
    end
    lat = cyc - ack_cyc;
    check("res_stb_seen", got, 1);
    v = bus.RES_VAL;
    e = bus.RES_ERR;
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
    check("res_stb_drop", bus.RES_STB, 0);
  endtask

  task automatic run_expr(input string s, input logic [15:0] ev, input logic [2:0] ee,
                          input string tag);
    logic [15:0] v;
    logic [2:0]  e;
    int          lat;
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    get_result(v, e, lat);
    check({tag, "_val"}, v, ev);
    check({tag, "_err"}, e, ee);
    check({tag, "_lat"}, lat, 2);
  endtask

  initial begin
    bit          stable;
    int          acks;
    bit          got;

    RST         = 1'b1;
    bus.IN_STB  = 1'b0;
    bus.IN_CHAR = 8'h00;
    bus.RES_ACK = 1'b0;
    repeat (3) tick();
    check("rst_in_ack",  bus.IN_ACK,  0);
    check("rst_res_stb", bus.RES_STB, 0);
    check("rst_res_val", bus.RES_VAL, 0);
    check("rst_res_err", bus.RES_ERR, 0);
    RST = 1'b0;
    tick();

    run_expr("34+=",    16'd7,      3'd0, "add");
    run_expr("35-=",    16'hFFFE,   3'd0, "sub_neg");
    run_expr("92-3*=",  16'd21,     3'd0, "sub_mul");
    run_expr("07-2/=",  16'hFFFD,   3'd0, "div_trunc");
    run_expr("6 3 /=",  16'd2,      3'd0, "spaces");
    run_expr("50/=",    16'd0,      3'd3, "div0");
    run_expr("+=",      16'd0,      3'd1, "underflow_op");
    run_expr("12=",     16'd0,      3'd5, "leftover");
    run_expr("4x=",     16'd0,      3'd4, "bad_char");
    run_expr("=",       16'd0,      3'd1, "empty_eq");
    run_expr("5+3=",    16'd0,      3'd1, "first_err_kept");
    run_expr("123456789=", 16'd0,   3'd2, "overflow");
    run_expr("8=",      16'd8,      3'd0, "after_ovf");

    // Result backpressure with a pending input character.
    for (int i = 0; i < 4; i++) send_char(i == 0 ? CH_0 + 8'd3 : i == 1 ? CH_0 + 8'd4 :
                                          i == 2 ? CH_PLUS : CH_EQ);
    bus.IN_STB  = 1'b1;
    bus.IN_CHAR = CH_0 + 8'd5;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.RES_STB) got = 1'b1;
      else tick();
    end
    check("bp_res_stb_seen", got, 1);
    stable = 1'b1;
    acks   = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.IN_ACK) acks++;
      if (bus.RES_STB !== 1'b1 || bus.RES_VAL !== 16'd7 || bus.RES_ERR !== 3'd0) stable = 1'b0;
      tick();
    end
    check("bp_res_stable", stable, 1);
    check("bp_no_in_ack", acks, 0);
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
    check("bp_release_stb", bus.RES_STB, 0);
    check("bp_idle_no_ack", bus.IN_ACK, 0);
    tick();
    check("bp_pending_ack", bus.IN_ACK, 1);
    bus.IN_STB = 1'b0;
    tick();
    run_expr("=",       16'd5,      3'd0, "bp_pending_char");

    // Reset in the middle of an expression discards the partial stack.
    send_char(CH_0 + 8'd3);
    send_char(CH_0 + 8'd4);
    RST = 1'b1;
    tick();
    check("mid_rst_in_ack",  bus.IN_ACK,  0);
    check("mid_rst_res_stb", bus.RES_STB, 0);
    check("mid_rst_res_val", bus.RES_VAL, 0);
    check("mid_rst_res_err", bus.RES_ERR, 0);
    tick();
    RST = 1'b0;
    tick();
    run_expr("2=",      16'd2,      3'd0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
